// File: rtl/pcie_rq_arbiter.sv
// Packet-granular round-robin arbiter for the CPM RQ AXI-stream port, with a 2-entry output skid buffer.
// Optional macro RQ_ARB_PRIO0_EN gives requester 0 strict priority at packet boundaries.
module pcie_rq_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 512,
    parameter int USER_WIDTH = 137,
    parameter int KEEP_WIDTH = 16
) (
    input  logic                          user_clk,
    input  logic                          user_rst_n,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_rq_tdata,
    input  logic [NUM_REQ*USER_WIDTH-1:0] s_rq_tuser,
    input  logic [NUM_REQ*KEEP_WIDTH-1:0] s_rq_tkeep,
    input  logic [NUM_REQ-1:0]            s_rq_tlast,
    input  logic [NUM_REQ-1:0]            s_rq_tvalid,
    output logic [NUM_REQ-1:0]            s_rq_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_rq_tdata,
    output logic [USER_WIDTH-1:0]         m_axis_rq_tuser,
    output logic [KEEP_WIDTH-1:0]         m_axis_rq_tkeep,
    output logic                          m_axis_rq_tlast,
    output logic                          m_axis_rq_tvalid,
    input  logic [3:0]                    m_axis_rq_tready,
    output logic [NUM_REQ-1:0]            grant_onehot,
    output logic [31:0]                   pkt_cnt
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic {IDLE, PKT} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [USER_WIDTH-1:0] user;
        logic [KEEP_WIDTH-1:0] keep;
        logic                  last;
    } beat_t;

    state_t             state, state_next;
    logic [NUM_REQ-1:0] grant_next;
    logic [PTR_W-1:0]   grant_idx, grant_idx_next;
    logic [PTR_W-1:0]   rr_ptr, rr_next;
    logic [PTR_W-1:0]   sel_idx, cand_idx;
    logic               sel_found;

    beat_t              in_beat;
    logic               in_valid;
    beat_t              buf_q [2];
    logic               wr_ptr, rd_ptr;
    logic [1:0]         count;
    logic               full, push, pop;
    logic               unused_tready;

    assign unused_tready = &{1'b0, m_axis_rq_tready[3:1]};

    // Route the granted requester's beat onto the internal bus.
    always_comb begin
        in_beat  = '0;
        in_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                in_beat.data = s_rq_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                in_beat.user = s_rq_tuser[i*USER_WIDTH +: USER_WIDTH];
                in_beat.keep = s_rq_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
                in_beat.last = s_rq_tlast[i];
                in_valid     = s_rq_tvalid[i];
            end
        end
    end

    // First valid requester at or above the rr pointer, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_idx = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!sel_found && s_rq_tvalid[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
`ifdef RQ_ARB_PRIO0_EN
        if (s_rq_tvalid[0]) begin
            sel_found = 1'b1;
            sel_idx   = '0;
        end
`endif
    end

    assign full        = (count == 2'd2);
    assign push        = (state == PKT) && in_valid && !full;
    assign pop         = (count != 2'd0) && m_axis_rq_tready[0];
    assign s_rq_tready = ((state == PKT) && !full) ? grant_onehot : '0;

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        state_next     = state;
        grant_next     = grant_onehot;
        grant_idx_next = grant_idx;
        rr_next        = rr_ptr;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    state_next     = PKT;
                    grant_next     = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx;
                    grant_idx_next = sel_idx;
                end
            end
            PKT: begin
                if (push && in_beat.last) begin
                    state_next = IDLE;
                    grant_next = '0;
`ifdef RQ_ARB_PRIO0_EN
                    if (grant_idx != '0)
`endif
                    rr_next = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state        <= IDLE;
            grant_onehot <= '0;
            grant_idx    <= '0;
            rr_ptr       <= '0;
        end else begin
            state        <= state_next;
            grant_onehot <= grant_next;
            grant_idx    <= grant_idx_next;
            rr_ptr       <= rr_next;
        end
    end

    // NOTE: the two buffer entries are reset because they drive the master outputs directly.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            pkt_cnt  <= 32'd0;
        end else begin
            if (push) begin
                buf_q[wr_ptr] <= in_beat;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                if (buf_q[rd_ptr].last)
                    pkt_cnt <= pkt_cnt + 32'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign m_axis_rq_tvalid = (count != 2'd0);
    assign m_axis_rq_tdata  = buf_q[rd_ptr].data;
    assign m_axis_rq_tuser  = buf_q[rd_ptr].user;
    assign m_axis_rq_tkeep  = buf_q[rd_ptr].keep;
    assign m_axis_rq_tlast  = buf_q[rd_ptr].last;

endmodule
